// File: rtl/bus_logger_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_logger_pkg
//  Description : Shared defaults, log entry layout and FSM state encoding
//                for the bus change logger.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_logger_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_TS_W   = 16;
    localparam int DEF_DEPTH  = 8;

    // One log record at the default widths: the new bus value and the cycle it changed.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_TS_W-1:0]   ts;
    } log_entry_t;

    // Capture FSM: PRIME takes one reference sample so enabling never logs a change.
    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        PRIME    = 2'd1,
        RUN      = 2'd2
    } log_state_t;

endpackage : bus_logger_pkg
`default_nettype wire

// File: rtl/bus_change_logger_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_change_logger_if
//  Description : Monitored bus input, control inputs and log stream outputs
//                of the bus change logger. master = logger, slave = user.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_change_logger_if
    import bus_logger_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TS_W   = DEF_TS_W,
    parameter int DEPTH  = DEF_DEPTH
) ();

    logic                     en;
    logic [DATA_W-1:0]        bus_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [TS_W-1:0]          out_ts;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     clear_ovf;

    modport master (
        input  en,
        input  bus_data,
        input  out_ready,
        input  clear_ovf,
        output out_valid,
        output out_data,
        output out_ts,
        output count,
        output overflow
    );

    modport slave (
        output en,
        output bus_data,
        output out_ready,
        output clear_ovf,
        input  out_valid,
        input  out_data,
        input  out_ts,
        input  count,
        input  overflow
    );

endinterface : bus_change_logger_if
`default_nettype wire

// File: rtl/bus_change_logger_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : logger_fifo
//  Description : First-word-fall-through FIFO for log entries. Pointers carry
//                an extra wrap bit so full and empty come from a compare.
//                A push into a full FIFO is accepted only if a pop frees a
//                slot on the same edge; otherwise it is dropped and flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module logger_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     valid_o,
    output logic                     drop_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              empty;
    logic              full;
    logic              do_pop;
    logic              do_push;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty;
    // A simultaneous pop frees the slot the push needs.
    assign do_push = push_i && (!full || do_pop);

    assign valid_o = !empty;
    assign drop_o  = push_i && !do_push;
    assign count_o = wr_ptr_q - rd_ptr_q;
    // Head is masked while empty so stale storage never shows on the outputs.
    assign rdata_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance on accepted push/pop; reset discards all queued entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Entry storage; contents are only visible through the masked head.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule : logger_fifo
`default_nettype wire

// File: rtl/bus_change_logger.sv
`default_nettype none
// ============================================================================
//  Module      : bus_change_logger
//  Description : Watches a bus word and logs every value change together with
//                a free-running cycle timestamp into a FWFT FIFO. A sticky
//                overflow flag records any change lost to a full FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_change_logger
    import bus_logger_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TS_W   = DEF_TS_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bus_change_logger_if.master  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    log_state_t              state_q;
    log_state_t              state_d;
    logic [TS_W-1:0]         ts_q;
    logic [DATA_W-1:0]       prev_q;
    logic [DATA_W-1:0]       prev_d;
    logic                    overflow_q;
    logic                    overflow_d;

    logic                    push;
    logic                    drop;
    logic                    fifo_valid;
    logic [DATA_W+TS_W-1:0]  fifo_rdata;
    logic [CNT_W-1:0]        fifo_count;

    // Free-running timestamp, wraps naturally and ignores the enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + 1'b1;
    end

    // FSM, reference sample and overflow flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DISABLED;
            prev_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            overflow_q <= overflow_d;
        end
    end

    // Next state, reference reload and change detection.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        push    = 1'b0;
        case (state_q)
            DISABLED: begin
                if (bus.en) state_d = PRIME;
            end
            PRIME: begin
                prev_d  = bus.bus_data;
                state_d = bus.en ? RUN : DISABLED;
            end
            RUN: begin
                prev_d = bus.bus_data;
                if (!bus.en) state_d = DISABLED;
                else         push    = (bus.bus_data != prev_q);
            end
            default: state_d = DISABLED;
        endcase
    end

    // Sticky overflow: a drop on the same edge as a clear keeps it set.
    always_comb begin
        overflow_d = (overflow_q && !bus.clear_ovf) || drop;
    end

    logger_fifo #(
        .WIDTH (DATA_W + TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i ({bus.bus_data, ts_q}),
        .pop_i   (bus.out_ready),
        .rdata_o (fifo_rdata),
        .valid_o (fifo_valid),
        .drop_o  (drop),
        .count_o (fifo_count)
    );

    assign bus.out_valid = fifo_valid;
    assign bus.out_data  = fifo_rdata[DATA_W+TS_W-1:TS_W];
    assign bus.out_ts    = fifo_rdata[TS_W-1:0];
    assign bus.count     = fifo_count;
    assign bus.overflow  = overflow_q;

endmodule : bus_change_logger
`default_nettype wire
